nibble_inv_arbiter: RTL and testbench



---
 rtl/nibble_inv_arbiter.sv | 67 ++++++
 tb/tb_nibble_inv_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nibble_inv_arbiter.sv
// nibble_inv_arbiter: round-robin shared XOR-mask datapath with a registered valid/ready output
module nibble_inv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  cfg_we,
  input  logic [IDW-1:0]        cfg_sel,
  input  logic [WIDTH-1:0]      cfg_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] mask_q [NREQ];
  logic [IDW-1:0]   ptr_q, ptr_d, grant;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q;
  logic             found, can_accept, xfer;
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end
  assign can_accept = (state_q == EMPTY) || out_ready;
  assign xfer       = found && can_accept;
  assign req_ready  = xfer ? (NREQ'(1) << grant) : '0;
  assign ptr_d      = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
  // mask read here is the pre-edge value, so a same-edge cfg write affects only later transfers
  assign out_data_d = req_data[int'(grant)*WIDTH +: WIDTH] ^ mask_q[grant];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      ptr_q      <= '0;
      for (int i = 0; i < NREQ; i++) mask_q[i] <= '1;
    end else begin
      if (xfer) begin
        state_q    <= FULL;
        out_data_q <= out_data_d;
        out_id_q   <= grant;
        ptr_q      <= ptr_d;
      end else if (state_q == FULL && out_ready) begin
        state_q <= EMPTY;
      end
      if (cfg_we && int'(cfg_sel) < NREQ) mask_q[cfg_sel] <= cfg_mask;
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
endmodule

// File: tb/tb_nibble_inv_arbiter.sv
// tb_nibble_inv_arbiter: directed plan plus random traffic against a behavioural model (NREQ=3)
module tb_nibble_inv_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 3;
  localparam int IDW   = $clog2(NREQ);
  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic                  cfg_we = 1'b0;
  logic [IDW-1:0]        cfg_sel = '0;
  logic [WIDTH-1:0]      cfg_mask = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] m_mask [NREQ];
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  nibble_inv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_mask[i] = '1;
    m_ptr = 0;
    m_valid = 0;
    m_data = '0;
    m_id = 0;
  endtask
  // checks the current cycle against the model, then advances the model and the clock
  task automatic tick();
    int g;
    bit acc;
    logic [NREQ-1:0] rr;
    #2;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    acc = !m_valid || out_ready;
    rr = (g >= 0 && acc) ? NREQ'(1 << g) : '0;
    if (!rst) chk("req_ready", req_ready, rr);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
    if (rst) model_reset();
    else begin
      if (g >= 0 && acc) begin
        m_data = req_data[g*WIDTH +: WIDTH] ^ m_mask[g];
        m_id = g;
        m_valid = 1;
        m_ptr = (g + 1) % NREQ;
      end else if (m_valid && out_ready) m_valid = 0;
      if (cfg_we && int'(cfg_sel) < NREQ) m_mask[cfg_sel] = cfg_mask;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    // single request after reset
    out_ready = 1'b1;
    req_valid = 3'b001;
    req_data = 12'h00A;
    tick();
    chk("single_data", out_data, 4'h5);
    chk("single_id", out_id, 0);
    req_valid = '0;
    tick();
    // round-robin between 0 and 1
    req_valid = 3'b011;
    req_data = 12'h03C;
    repeat (6) tick();
    // backpressure
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (2) tick();
    req_valid = '0;
    tick();
    // config write colliding with a transfer from requester 1
    req_valid = 3'b010;
    req_data = 12'h060;
    cfg_we = 1'b1;
    cfg_sel = 2'd1;
    cfg_mask = 4'h0;
    tick();
    chk("cfg_old_mask", out_data, 4'h9);
    cfg_we = 1'b0;
    tick();
    chk("cfg_new_mask", out_data, 4'h6);
    // reset while holding a stalled result
    req_valid = 3'b011;
    req_data = 12'h03C;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    out_ready = 1'b1;
    tick();
    chk("rst_first_id", out_id, 0);
    // out-of-range config select is ignored
    cfg_we = 1'b1;
    cfg_sel = 2'd3;
    cfg_mask = 4'h0;
    req_valid = '0;
    tick();
    cfg_we = 1'b0;
    req_data = 12'hFFF;
    for (int i = 0; i < NREQ; i++) begin
      req_valid = NREQ'(1 << i);
      tick();
      chk("badsel_data", out_data, 4'h0);
    end
    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      req_valid = NREQ'($urandom);
      req_data = NREQ*WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_sel = IDW'($urandom);
      cfg_mask = WIDTH'($urandom);
      tick();
    end
    rst = 1'b0;
    cfg_we = 1'b0;
    req_valid = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
